// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_XFER_HI,
    ST_XFER_LO,
    ST_RESP
  } state_e;

  // Wait-state count used when the top is instantiated without an override.
  localparam int unsigned DEFAULT_WAIT_STATES = 1;

  // Bits needed to count 0..wait_states-1; never narrower than one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned wait_states);
    return (wait_states > 0) ? $clog2(wait_states + 1) : 1;
  endfunction

  localparam int unsigned WAIT_CNT_W = wait_cnt_width(DEFAULT_WAIT_STATES);

  // True when every word touched by the request exists. The upper word
  // address is formed one bit wider than the request so that a double
  // access at the top of the address space cannot wrap back to zero.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic dbl,
                                         input int unsigned depth);
    logic [32:0] last;
    last = {1'b0, addr} + {32'd0, dbl};
    return last < {1'b0, depth};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM: one read or write per cycle, read-first,
// contents are not reset.
module dmem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write the addressed word and register its previous contents for reading.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller for the MEM stage: request/response handshake,
// optional wait states, double-word (big-endian) access and a sequential
// clear of the whole array after reset.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned WAIT_STATES    = DEFAULT_WAIT_STATES,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic                req_dbl_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0] req_wdata_i,
  output logic                rsp_valid_o,
  output logic [2*DATA_W-1:0] rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                init_busy_o
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCW = wait_cnt_width(WAIT_STATES);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [AW-1:0]  CLR_LAST  = AW'(DEPTH - 1);
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                ready_q;

  logic                wr_q, dbl_q, err_q;
  logic [AW-1:0]       addr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0]   hi_q;

  logic [2*DATA_W-1:0] rsp_rdata_q;
  logic                rsp_err_q;

  logic                accept;
  logic                req_ok;
  logic [2*DATA_W-1:0] resp_data;

  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  assign accept = req_valid_i && ready_q;
  assign req_ok = addr_in_range(32'(req_addr_i), req_dbl_i, DEPTH);

  // Writes and failed requests answer with zero; reads combine the word
  // captured during the high transfer with the word just read.
  assign resp_data = (err_q || wr_q) ? '0 : {hi_q, ram_rdata};

  // Next-state logic and array access; the array is only touched in INIT
  // and the two transfer states.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_wdata  = wdata_q[DATA_W-1:0];
    case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          wait_cnt_d = '0;
          if (!req_ok) begin
            state_d = ST_RESP;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
          end else if (req_dbl_i) begin
            state_d = ST_XFER_HI;
          end else begin
            state_d = ST_XFER_LO;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = dbl_q ? ST_XFER_HI : ST_XFER_LO;
        end
      end
      ST_XFER_HI: begin
        ram_we    = wr_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q[2*DATA_W-1:DATA_W];
        state_d   = ST_XFER_LO;
      end
      ST_XFER_LO: begin
        ram_we    = wr_q;
        ram_addr  = dbl_q ? addr_q + AW'(1) : addr_q;
        ram_wdata = wdata_q[DATA_W-1:0];
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // State, counters and the registered ready flag, which stays low
  // throughout reset even when the controller resets straight into IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= (state_d == ST_IDLE);
    end
  end

  // Latch the request at acceptance and capture the high read word at the
  // end of the low transfer, once the synchronous array has produced it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= 1'b0;
      dbl_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
    end else if (state_q == ST_IDLE && accept) begin
      wr_q    <= req_write_i;
      dbl_q   <= req_dbl_i;
      err_q   <= !req_ok;
      addr_q  <= req_addr_i[AW-1:0];
      wdata_q <= req_wdata_i;
      hi_q    <= '0;
    end else if (state_q == ST_XFER_LO && dbl_q && !wr_q) begin
      hi_q <= ram_rdata;
    end
  end

  // Keep the last response visible until the next RESP replaces it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (state_q == ST_RESP) begin
      rsp_rdata_q <= resp_data;
      rsp_err_q   <= err_q;
    end
  end

  assign req_ready_o = ready_q;
  assign init_busy_o = (state_q == ST_INIT);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_valid_o ? resp_data : rsp_rdata_q;
  assign rsp_err_o   = rsp_valid_o ? err_q : rsp_err_q;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised single-port data memory with a request/response handshake, configurable wait states and a sequential clear after reset. Adds 32-bit double-word access for PC push/pop (CALL/RET/INT) and an out-of-range error response. Sits in the MEM stage. The pipeline stalls while req_ready or init_busy indicates the memory is unavailable.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 16, request address width
DEPTH, 2048, number of words; legal addresses are 0..DEPTH-1
WAIT_STATES, 1, extra cycles inserted before each access; 0 is legal
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip clearing and contents are undefined

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low; asserting it forces reset state immediately
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready at posedge
req_write  in  1  1 = write, 0 = read
req_dbl  in  1  1 = double-word access (addr, addr+1)
req_addr  in  ADDR_W  word address
req_wdata  in  2*DATA_W  write data; single access uses the low half only
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  2*DATA_W  read data, valid while rsp_valid is high
rsp_err  out  1  out-of-range flag, valid while rsp_valid is high
init_busy  out  1  high while clearing

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT if CLEAR_ON_RESET, else IDLE
  - clear counter=0
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - init_busy=1 if CLEAR_ON_RESET, else 0
- Reset mid-operation aborts the request with no response. A double write that is half done keeps its first word, then the array clear applies if enabled.
- States: INIT, IDLE, WAIT, XFER_HI, XFER_LO, RESP.
- INIT: write 0 to word[counter], counter++ every cycle. After word DEPTH-1 is cleared, go to IDLE and drop init_busy. INIT lasts exactly DEPTH cycles. req_ready=0 throughout.
- IDLE: req_ready=1, and only in IDLE. On acceptance, latch write, dbl, addr and wdata. Inputs are ignored after acceptance.
- Range check at acceptance: error if addr >= DEPTH, or if dbl and addr >= DEPTH-1 (addr+1 computed at ADDR_W+1 bits, so no wrap to 0).
  - On error: go to RESP, rsp_err=1, rsp_rdata=0, no array access.
- WAIT: counts WAIT_STATES cycles. When WAIT_STATES=0 it is skipped.
- Double access: XFER_HI accesses word addr, then XFER_LO accesses addr+1 (big-endian).
  - addr carries bits [2*DATA_W-1:DATA_W]; addr+1 carries bits [DATA_W-1:0].
- Single access: XFER_LO only, at word addr.
  - Write uses wdata[DATA_W-1:0].
  - Read returns the word in the low half; the high half is 0.
- Array is synchronous: one read or write per cycle. Read data is captured into rsp_rdata at the end of the XFER state.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_err=0 on success.
  - rsp_rdata=0 for writes.
  - rsp_rdata and rsp_err hold their value until the next RESP.
- Latency, counted from the acceptance edge (cycle T):
  - single: rsp_valid in cycle T+2+WAIT_STATES
  - double: rsp_valid in cycle T+3+WAIT_STATES
  - error: rsp_valid in cycle T+1
- Throughput: the next acceptance is possible in the cycle after RESP.

Decomposition:
- Package dmem_pkg:
  - state enum (INIT..RESP)
  - function addr_in_range(addr, dbl, DEPTH)
  - localparam for the wait-counter width, $clog2(WAIT_STATES+1)
- Sub-module dmem_array: single-port synchronous RAM (DATA_W, DEPTH) with ports we, addr, wdata, rdata; no reset on contents.
- The controller FSM, clear counter and wait counter live in data_memory_ctrl.

Test Plan:
- Reset low 3 cycles, then release with DEPTH=2048, CLEAR_ON_RESET=1 -> init_busy high for exactly 2048 cycles, req_ready=0 until it falls; a read of addr 0x07FF then returns 0x0000.
- Single write addr 0x0010 data 0x0000_BEEF, then read 0x0010 with WAIT_STATES=1 -> write response in cycle T+3 with rsp_err=0; read returns 0x0000_BEEF.
- Double write addr 0x0100 data 0x1234_5678, then single reads of 0x0100 and 0x0101 -> 0x1234 and 0x5678; double read of 0x0100 returns 0x1234_5678 in cycle T+4.
- Single read 0x0800 and double write 0x07FF -> rsp_valid at T+1 with rsp_err=1, rsp_rdata=0; word 0x07FF keeps its prior value.
- WAIT_STATES=0, back-to-back requests held on req_valid -> acceptances every 3 cycles for single access; req_ready low outside IDLE.
- Reset asserted during XFER_LO of a double write -> no rsp_valid; INIT restarts; after clearing, both addr and addr+1 read 0.
